// File: rtl/lo_nco.sv
// lo_nco: quadrature local-oscillator NCO with quarter-wave sine table.
// Produces cosine (lo_i) and sine (lo_q) samples from a PSZ-bit phase
// accumulator, with a 4-register pipeline from accumulator to outputs.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   en         in   advance accumulator / produce one sample
//   ftw        in   frequency tuning word (phase step per sample)
//   ftw_load   in   capture ftw into the tuning register
//   poff       in   16-bit phase offset, 2^16 = one full turn
//   phase_clr  in   synchronous accumulator clear (beats en)
//   lo_i       out  cosine sample, signed DSZ bits
//   lo_q       out  sine sample, signed DSZ bits
//   lo_valid   out  lo_i/lo_q carry a new sample
//
// Optional build macro: NCO_DITHER_EN adds 16-bit LFSR phase dither
// below the lookup LSB. Undefined by default (fully deterministic).

module lo_nco #(
    parameter int DSZ = 16,
    parameter int PSZ = 32,
    parameter int ASZ = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [PSZ-1:0] ftw,
    input  logic           ftw_load,
    input  logic [15:0]    poff,
    input  logic           phase_clr,
    output logic [DSZ-1:0] lo_i,
    output logic [DSZ-1:0] lo_q,
    output logic           lo_valid
);

    localparam int TW = ASZ - 2;
    localparam int TN = 1 << TW;

    // Quarter-wave entry k = round(32767*sin(pi/2*(k+0.5)/TN)),
    // evaluated at elaboration with a Q30 Taylor series.
    function automatic logic [14:0] qsin(input int k);
        longint pi_q30;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint r;
        pi_q30 = 64'sd3373259426;
        x      = (pi_q30 * longint'(2 * k + 1)) >>> (TW + 2);
        x2     = (x * x) >>> 30;
        term   = x;
        sum    = x;
        for (int n = 1; n < 8; n++) begin
            term = -((term * x2) >>> 30);
            term = term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        r = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
        return r[14:0];
    endfunction

    logic [14:0] rom [TN];

    for (genvar k = 0; k < TN; k++) begin : g_rom
        localparam logic [14:0] V = qsin(k);
        assign rom[k] = V;
    end

    // Tuning register and phase accumulator
    logic [PSZ-1:0] tw_q, tw_d;
    logic [PSZ-1:0] acc_q, acc_d;

    always_comb begin
        tw_d  = tw_q;
        acc_d = acc_q;
        if (ftw_load)
            tw_d = ftw;
        // Accumulation uses the previously loaded word.
        if (phase_clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + tw_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tw_q  <= '0;
            acc_q <= '0;
        end else begin
            tw_q  <= tw_d;
            acc_q <= acc_d;
        end
    end

    // Stage 1: add phase offset, keep top ASZ bits
    logic [PSZ-1:0] off_w;
    logic [ASZ-1:0] p_q, p_d;

    assign off_w = {poff, {(PSZ-16){1'b0}}};

`ifdef NCO_DITHER_EN
    localparam int DSH = PSZ - ASZ - 16;

    logic [15:0]    lfsr_q, lfsr_d;
    logic [PSZ-1:0] dith_w;

    // Fibonacci LFSR, taps 16,14,13,11
    always_comb begin
        lfsr_d = lfsr_q;
        if (en)
            lfsr_d = {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= lfsr_d;
    end

    assign dith_w = PSZ'(lfsr_q) << DSH;

    always_comb begin
        p_d = ASZ'((acc_q + off_w + dith_w) >> (PSZ - ASZ));
    end
`else
    always_comb begin
        p_d = ASZ'((acc_q + off_w) >> (PSZ - ASZ));
    end
`endif

    // Stage 2: quadrant folding for both channels
    logic [1:0]    quad, cquad;
    logic [TW-1:0] idx;
    logic [TW-1:0] is_q, is_d;
    logic [TW-1:0] ic_q, ic_d;
    logic          ns1_q, ns1_d;
    logic          nc1_q, nc1_d;

    always_comb begin
        quad  = p_q[ASZ-1 -: 2];
        idx   = p_q[TW-1:0];
        cquad = quad + 2'd1;
        // Odd quadrants run the quarter table backwards.
        is_d  = quad[0]  ? ~idx : idx;
        ic_d  = cquad[0] ? ~idx : idx;
        ns1_d = quad[1];
        nc1_d = cquad[1];
    end

    // Stage 3: table read
    logic [14:0] ts_q, ts_d;
    logic [14:0] tc_q, tc_d;
    logic        ns2_q, nc2_q;

    always_comb begin
        ts_d = rom[is_q];
        tc_d = rom[ic_q];
    end

    // Stage 4: sign restore
    logic [DSZ-1:0] oi_q, oi_d;
    logic [DSZ-1:0] oq_q, oq_d;
    logic [DSZ-1:0] ext_s, ext_c;
    logic [3:0]     vld_q, vld_d;
    logic [2:0]     prm_q, prm_d;

    always_comb begin
        ext_s = DSZ'(ts_q);
        ext_c = DSZ'(tc_q);
        oq_d  = ns2_q ? -ext_s : ext_s;
        oi_d  = nc2_q ? -ext_c : ext_c;
        // Hold outputs at zero until en has primed the pipe after reset.
        if (!prm_q[2]) begin
            oq_d = '0;
            oi_d = '0;
        end
        vld_d = {vld_q[2:0], en};
        prm_d = {prm_q[1:0], prm_q[0] | en};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q   <= '0;
            is_q  <= '0;
            ic_q  <= '0;
            ns1_q <= 1'b0;
            nc1_q <= 1'b0;
            ts_q  <= '0;
            tc_q  <= '0;
            ns2_q <= 1'b0;
            nc2_q <= 1'b0;
            oi_q  <= '0;
            oq_q  <= '0;
            vld_q <= '0;
            prm_q <= '0;
        end else begin
            p_q   <= p_d;
            is_q  <= is_d;
            ic_q  <= ic_d;
            ns1_q <= ns1_d;
            nc1_q <= nc1_d;
            ts_q  <= ts_d;
            tc_q  <= tc_d;
            ns2_q <= ns1_q;
            nc2_q <= nc1_q;
            oi_q  <= oi_d;
            oq_q  <= oq_d;
            vld_q <= vld_d;
            prm_q <= prm_d;
        end
    end

    assign lo_i     = oi_q;
    assign lo_q     = oq_q;
    assign lo_valid = vld_q[3];

endmodule

// File: tb/tb_lo_nco.sv
// tb_lo_nco: directed vector bench for lo_nco (default build).
// Static-phase table vectors plus rotation, clear/load, hold and reset sequences.

module tb_lo_nco;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] ftw;
    logic        ftw_load;
    logic [15:0] poff;
    logic        phase_clr;
    logic [15:0] lo_i;
    logic [15:0] lo_q;
    logic        lo_valid;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] ftw;
        logic [15:0] poff;
        int          ei;
        int          eq;
    } vec_t;

    vec_t vt [11];
    int   rot_i [4];
    int   rot_q [4];

    lo_nco dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ftw       (ftw),
        .ftw_load  (ftw_load),
        .poff      (poff),
        .phase_clr (phase_clr),
        .lo_i      (lo_i),
        .lo_q      (lo_q),
        .lo_valid  (lo_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int ei, input int eq,
                           input int ev);
        chk({name, ".i"}, int'($signed(lo_i)), ei);
        chk({name, ".q"}, int'($signed(lo_q)), eq);
        chk({name, ".v"}, int'(lo_valid), ev);
    endtask

    // Release reset with en high; outputs stay zero for three
    // cycles and the first sample (phase 0) lands on the fourth.
    task automatic release_and_prime(input string name);
        reset = 1'b0;
        en    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out({name, ".fill"}, 0, 0, 0);
        end
        tick();
        chk_out({name, ".first"}, 32767, 101, 1);
    endtask

    initial begin
        vt[0]  = '{32'h0000_0000, 16'h0000,  32767,    101};
        vt[1]  = '{32'h0000_0000, 16'h4000,   -101,  32767};
        vt[2]  = '{32'h0000_0000, 16'h8000, -32767,   -101};
        vt[3]  = '{32'h0000_0000, 16'hC000,    101, -32767};
        vt[4]  = '{32'h0000_0000, 16'h0040,  32766,    302};
        vt[5]  = '{32'h0000_0000, 16'h003F,  32767,    101};
        vt[6]  = '{32'h0000_0000, 16'h2000,  23099,  23241};
        vt[7]  = '{32'h4000_0000, 16'h0000,   -101,  32767};
        vt[8]  = '{32'hC000_0000, 16'h0000,    101, -32767};
        vt[9]  = '{32'h4000_0000, 16'hC000,  32767,    101};
        vt[10] = '{32'h0000_0000, 16'hFFC0,  32767,   -101};

        rot_i = '{32767, -101, -32767, 101};
        rot_q = '{101, 32767, -101, -32767};

        reset     = 1'b1;
        en        = 1'b0;
        ftw       = '0;
        ftw_load  = 1'b0;
        poff      = '0;
        phase_clr = 1'b0;

        tick();
        tick();
        chk_out("reset", 0, 0, 0);
        release_and_prime("start");

        // Quarter-turn rotation; the load must not affect the load cycle.
        ftw      = 32'h4000_0000;
        ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 8; j++) begin
            tick();
            chk_out($sformatf("rot%0d", j), rot_i[j % 4], rot_q[j % 4], 1);
        end

        // Clear and reload to zero together -> settles to phase 0.
        ftw       = '0;
        ftw_load  = 1'b1;
        phase_clr = 1'b1;
        tick();
        ftw_load  = 1'b0;
        phase_clr = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 6; j++) begin
            tick();
            chk_out($sformatf("clr%0d", j), 32767, 101, 1);
        end

        // Hold: stop after five quarter steps, phase stays at 90 deg.
        ftw       = 32'h4000_0000;
        ftw_load  = 1'b1;
        phase_clr = 1'b1;
        tick();
        ftw_load  = 1'b0;
        phase_clr = 1'b0;
        repeat (5) tick();
        en = 1'b0;
        repeat (6) tick();
        chk_out("hold", -101, 32767, 0);
        tick();
        chk_out("hold2", -101, 32767, 0);

        // Static table vectors
        en = 1'b1;
        for (int v = 0; v < 11; v++) begin
            ftw       = vt[v].ftw;
            poff      = vt[v].poff;
            ftw_load  = 1'b1;
            phase_clr = 1'b1;
            tick();
            ftw_load  = 1'b0;
            phase_clr = 1'b0;
            repeat (5) tick();
            chk_out($sformatf("vec%0d", v), vt[v].ei, vt[v].eq, 1);
        end

        // Mid-run asynchronous reset
        poff     = '0;
        ftw      = 32'h4000_0000;
        ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        repeat (6) tick();
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0);
        tick();
        chk_out("rst_held", 0, 0, 0);
        release_and_prime("mid");
        tick();
        chk_out("mid.next", 32767, 101, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
